// File: rtl/exhaustive_vec_sweep.sv
// Exhaustive stimulus sweeper: walks every IN_W-bit vector into a combinational unit and
// compares its outputs against a golden model on the last dwell cycle of each vector.
module exhaustive_vec_sweep #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 3,
  parameter int DWELL = 60,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] gold_out,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] mismatch_cnt,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    stim_q, stim_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               sample_q, sample_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    ffVec_q, ffVec_d;
  logic               ffValid_q, ffValid_d;

  logic isLast;
  logic isMismatch;

  assign isLast     = (stim_q == {IN_W{1'b1}});
  assign isMismatch = (dut_out != gold_out);

  // sample_q doubles as the compare-cycle flag, so the strobe and the comparison can never disagree
  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    dwell_d   = dwell_q;
    sample_d  = 1'b0;
    cnt_d     = cnt_q;
    ffVec_d   = ffVec_q;
    ffValid_d = ffValid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          stim_d    = '0;
          dwell_d   = '0;
          cnt_d     = '0;
          ffVec_d   = '0;
          ffValid_d = 1'b0;
          sample_d  = (DWELL_LAST == '0);
        end
      end
      RUN: begin
        if (sample_q) begin
          if (isMismatch) begin
            if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + ERR_W'(1);
            if (!ffValid_q) begin
              ffVec_d   = stim_q;
              ffValid_d = 1'b1;
            end
          end
          if (isLast) begin
            state_d = DONE;
          end else begin
            stim_d   = stim_q + IN_W'(1);
            dwell_d  = '0;
            sample_d = (DWELL_LAST == '0);
          end
        end else begin
          dwell_d  = dwell_q + DW_W'(1);
          sample_d = (dwell_d == DWELL_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      dwell_q   <= '0;
      sample_q  <= 1'b0;
      cnt_q     <= '0;
      ffVec_q   <= '0;
      ffValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      dwell_q   <= dwell_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      ffVec_q   <= ffVec_d;
      ffValid_q <= ffValid_d;
    end
  end

  assign stim             = stim_q;
  assign sample           = sample_q;
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign mismatch_cnt     = cnt_q;
  assign first_fail_vec   = ffVec_q;
  assign first_fail_valid = ffValid_q;

endmodule

// File: doc/exhaustive_vec_sweep.md
Name: exhaustive_vec_sweep

Overview:
- Synthesisable, parametrised successor to our fixed 3-input truth-table sweep.
- Drives every IN_W-bit input vector, 0 through 2^IN_W-1, onto a combinational unit under test, holding each vector for DWELL cycles.
- On the last dwell cycle of each vector, compares the unit's outputs against a golden model's outputs.
- Counts mismatches, records the first failing vector, and reports completion through a start/busy/done handshake.
- Sits beside ALU sub-blocks as an on-chip exhaustive self-checker.

Parameters:
IN_W, 3, width of the stimulus vector; sweep covers 2^IN_W vectors (1..16)
OUT_W, 3, width of the DUT and golden output buses compared (1..32)
DWELL, 60, clock cycles each vector is held (>=1)
ERR_W, 16, width of the saturating mismatch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  begin sweep; sampled on rising clk edge in IDLE or DONE
stim  output  IN_W  current stimulus vector driven to the DUT
dut_out  input  OUT_W  DUT response to stim
gold_out  input  OUT_W  golden-model response to stim
sample  output  1  one-cycle strobe: compare performed this cycle
busy  output  1  sweep in progress
done  output  1  sweep complete; level, held until next start or rst
mismatch_cnt  output  ERR_W  number of vectors where dut_out != gold_out
first_fail_vec  output  IN_W  stim value of the first mismatching vector
first_fail_valid  output  1  first_fail_vec holds a valid capture

Behaviour:
- Reset, asynchronous and any time including mid-sweep: state=IDLE, stim=0, dwell counter=0, sample=0, busy=0, done=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at a clk edge:
  - Next state is RUN, busy=1, done=0, stim=0, dwell=0.
  - mismatch_cnt, first_fail_vec and first_fail_valid are cleared in the same edge.
- RUN:
  - The dwell counter increments every cycle.
  - When dwell==DWELL-1, that cycle is the compare cycle: sample=1, and the comparison uses dut_out/gold_out present in that cycle.
- On the compare-cycle edge:
  - If dut_out != gold_out (full OUT_W bitwise compare), mismatch_cnt increments, saturating at 2^ERR_W-1, with no wrap.
  - If first_fail_valid was 0, first_fail_vec is loaded with stim and first_fail_valid is set to 1.
  - If stim != all-ones, stim increments and dwell returns to 0.
  - If stim == all-ones, the state moves to DONE: busy=0, done=1, stim holds the all-ones value.
- Comparison and final-vector detection happen in the same cycle.
- sample is a strobe: it is 1 only on compare cycles and 0 elsewhere.
- Timing:
  - busy is high for exactly 2^IN_W*DWELL cycles.
  - Exactly 2^IN_W sample pulses occur per sweep.
  - With DWELL=1, stim advances every cycle and sample stays high continuously while busy.
- start while in RUN is ignored; the sweep continues undisturbed.
- DONE holds all results stable until start or rst.
- dut_out and gold_out are ignored outside compare cycles.
- stim changes only on clk edges. The DUT path must settle within DWELL cycles; this is the integrator's responsibility.

Test Plan:
- Defaults, dut_out tied to gold_out; pulse start -> busy high 480 cycles, 8 sample pulses with stim 0..7, then done=1, mismatch_cnt=0, first_fail_valid=0.
- Defaults, dut_out differs from gold_out only when stim=5 -> mismatch_cnt=1, first_fail_vec=5, first_fail_valid=1, done=1 after 480 cycles.
- ERR_W=2, IN_W=3, dut_out=~gold_out for all vectors -> first_fail_vec=0, mismatch_cnt saturates at 3 and does not wrap to 0.
- IN_W=4, DWELL=1 -> sample high for 16 consecutive cycles, stim 0..15, busy for 16 cycles, done on the next cycle.
- Assert rst for one cycle at cycle 200 of a default sweep -> all outputs return to their reset values immediately; a later start restarts the sweep from stim=0 with counters cleared.
- start pulsed during RUN has no effect on stim or timing. start pulsed in DONE after a failing sweep clears mismatch_cnt and first_fail_valid and begins a new 480-cycle sweep.
